// File: rtl/sprite_writer.sv
// Sprite RAM writer: fills a WIDTH x HEIGHT pixel RAM either from a raster-ordered
// valid/ready pixel stream or with a single colour. A registered read port serves
// the renderer and returns 0 for coordinates outside the sprite.
module sprite_writer #(
  parameter int WIDTH     = 11,
  parameter int HEIGHT    = 16,
  parameter int PIX_BITS  = 3,
  parameter int ADDR_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                clear,
  input  logic [PIX_BITS-1:0] fill_rgb,
  input  logic                pix_valid,
  input  logic [PIX_BITS-1:0] pix_rgb,
  output logic                pix_ready,
  output logic                busy,
  output logic                done,
  input  logic [9:0]          rd_row,
  input  logic [9:0]          rd_col,
  output logic [PIX_BITS-1:0] rd_rgb
);

  localparam int NPIX     = WIDTH * HEIGHT;
  localparam int ROW_BITS = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r;
  logic [ROW_BITS-1:0]   row_r;
  logic [COL_BITS-1:0]   col_r;
  logic [ADDR_BITS-1:0]  addr_r;
  logic [PIX_BITS-1:0]   fill_r;
  logic                  pix_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic [PIX_BITS-1:0]   rd_rgb_r;

  logic                  we_s;
  logic [PIX_BITS-1:0]   wdata_s;
  logic                  rd_in_bounds_s;
  logic [ADDR_BITS-1:0]  rd_addr_s;

  logic [PIX_BITS-1:0]   mem [0:NPIX-1];

  assign pix_ready = pix_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign rd_rgb    = rd_rgb_r;

  // Write-port select: stream pixel during LOAD transfers, latched colour during CLEAR.
  // Writes are suppressed on a reset edge so an aborted operation stops immediately.
  always_comb begin
    we_s    = 1'b0;
    wdata_s = '0;
    if (!reset_n) begin
      we_s    = 1'b0;
      wdata_s = '0;
    end else begin
      case (state_r)
        LOAD: begin
          we_s    = pix_valid;
          wdata_s = pix_rgb;
        end
        CLEAR: begin
          we_s    = 1'b1;
          wdata_s = fill_r;
        end
        default: begin
          we_s    = 1'b0;
          wdata_s = '0;
        end
      endcase
    end
  end

  // Read-address decode: bounds check on the raw 10-bit coordinates before folding to an address.
  always_comb begin
    rd_in_bounds_s = (rd_col < 10'(WIDTH)) && (rd_row < 10'(HEIGHT));
    rd_addr_s      = ADDR_BITS'(rd_col) + ADDR_BITS'(rd_row) * ADDR_BITS'(WIDTH);
  end

  // Control FSM with raster counters and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      row_r       <= '0;
      col_r       <= '0;
      addr_r      <= '0;
      fill_r      <= '0;
      pix_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (clear) begin
            state_r     <= CLEAR;
            fill_r      <= fill_rgb;
            row_r       <= '0;
            col_r       <= '0;
            addr_r      <= '0;
            busy_r      <= 1'b1;
            pix_ready_r <= 1'b0;
          end else if (start) begin
            state_r     <= LOAD;
            row_r       <= '0;
            col_r       <= '0;
            addr_r      <= '0;
            busy_r      <= 1'b1;
            pix_ready_r <= 1'b1;
          end
        end
        LOAD: begin
          if (pix_valid) begin
            addr_r <= addr_r + ADDR_BITS'(1);
            if (col_r == COL_BITS'(WIDTH - 1)) begin
              col_r <= '0;
              if (row_r == ROW_BITS'(HEIGHT - 1)) begin
                state_r     <= DONE;
                pix_ready_r <= 1'b0;
                busy_r      <= 1'b0;
                done_r      <= 1'b1;
              end else begin
                row_r <= row_r + ROW_BITS'(1);
              end
            end else begin
              col_r <= col_r + COL_BITS'(1);
            end
          end
        end
        CLEAR: begin
          addr_r <= addr_r + ADDR_BITS'(1);
          if (addr_r == ADDR_BITS'(NPIX - 1)) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          pix_ready_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  // Sprite RAM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[addr_r] <= wdata_s;
    end
  end

  // Registered renderer read; old data is returned on a same-cycle write to the same address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_rgb_r <= '0;
    end else if (rd_in_bounds_s) begin
      rd_rgb_r <= mem[rd_addr_s];
    end else begin
      rd_rgb_r <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_writer.sv
// Directed testbench for sprite_writer: stream load, gapped load, colour fill,
// start/clear priority, out-of-bounds reads and reset abort.
module tb_sprite_writer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       clear;
  logic [2:0] fill_rgb;
  logic       pix_valid;
  logic [2:0] pix_rgb;
  logic       pix_ready;
  logic       busy;
  logic       done;
  logic [9:0] rd_row;
  logic [9:0] rd_col;
  logic [2:0] rd_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_writer #(
    .WIDTH(11), .HEIGHT(16), .PIX_BITS(3), .ADDR_BITS(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .fill_rgb(fill_rgb), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .pix_ready(pix_ready), .busy(busy), .done(done),
    .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] pat(input int idx, input bit inv);
    logic [2:0] v;
    v = 3'(idx % 8);
    return inv ? (3'd7 - v) : v;
  endfunction

  // Drives pixels from the current negedge on until 'count' transfers have been presented.
  task automatic feed(input int first, input int count, input bit gaps, input bit inv,
                      output int acc, output bit saw_done, output int rdy_cyc);
    int cyc;
    bit v;
    acc = 0; saw_done = 1'b0; rdy_cyc = 0; cyc = 0;
    while (acc < count && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done === 1'b1) saw_done = 1'b1;
      if (pix_ready === 1'b1) rdy_cyc++;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_valid = v;
      pix_rgb   = pat(first + acc, inv);
      if (v && pix_ready === 1'b1) acc++;
    end
  endtask

  task automatic do_read(input int row, input int col, output logic [2:0] data);
    @(negedge clk);
    rd_row = 10'(row);
    rd_col = 10'(col);
    @(negedge clk);
    data = rd_rgb;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; clear = 1'b0; fill_rgb = 3'd0;
    pix_valid = 1'b0; pix_rgb = 3'd0; rd_row = 10'd0; rd_col = 10'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pix_ready, busy, done} !== 3'b000 || rd_rgb !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready/busy/done=%b rd=%0d, want 000 rd=0",
               {pix_ready, busy, done}, rd_rgb);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_stream_load;
    int acc, rdy; bit sd; logic [2:0] d;
    @(negedge clk); start = 1'b1;
    feed(0, 176, 1'b0, 1'b0, acc, sd, rdy);
    @(negedge clk); pix_valid = 1'b0;
    n_checks++;
    if (rdy !== 176 || sd !== 1'b0) begin
      n_fail++; $display("FAIL load_ready_cycles: got %0d early_done=%0d, want 176 0", rdy, sd);
    end
    n_checks++;
    if (done !== 1'b1 || pix_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL load_done: got done=%b ready=%b busy=%b, want 1 0 0", done, pix_ready, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL load_done_width: got done=%b, want 0", done);
    end
    do_read(3, 5, d);
    n_checks++;
    if (d !== 3'd6) begin n_fail++; $display("FAIL load_read_3_5: got %0d, want 6", d); end
    do_read(15, 10, d);
    n_checks++;
    if (d !== 3'd7) begin n_fail++; $display("FAIL load_read_15_10: got %0d, want 7", d); end
    do_read(1, 0, d);
    n_checks++;
    if (d !== 3'd3) begin n_fail++; $display("FAIL load_read_1_0: got %0d, want 3", d); end
  endtask

  task automatic test_gapped_load;
    int acc, rdy, cyc, bad; bit sd; logic [2:0] d;
    // wipe the image first so the gapped load has to rebuild it
    @(negedge clk); clear = 1'b1; fill_rgb = 3'd0;
    @(negedge clk); clear = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    feed(0, 176, 1'b1, 1'b0, acc, sd, rdy);
    @(negedge clk); pix_valid = 1'b0;
    n_checks++;
    if (acc !== 176 || sd !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL gap_done: got accepted=%0d early=%0d done=%b, want 176 0 1", acc, sd, done);
    end
    bad = 0;
    for (int i = 0; i < 176; i++) begin
      do_read(i / 11, i % 11, d);
      if (d !== pat(i, 1'b0)) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL gap_image: got %0d wrong pixels, want 0", bad); end
  endtask

  task automatic test_clear;
    int cnt; logic [2:0] d;
    @(negedge clk); clear = 1'b1; fill_rgb = 3'b101;
    @(negedge clk); clear = 1'b0; fill_rgb = 3'b000;
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin cnt++; @(negedge clk); end
    n_checks++;
    if (cnt !== 176 || done !== 1'b1) begin
      n_fail++; $display("FAIL clear_busy: got busy=%0d done=%b, want 176 1", cnt, done);
    end
    do_read(0, 0, d);
    n_checks++;
    if (d !== 3'b101) begin n_fail++; $display("FAIL clear_read_0_0: got %0d, want 5", d); end
    do_read(15, 10, d);
    n_checks++;
    if (d !== 3'b101) begin n_fail++; $display("FAIL clear_read_15_10: got %0d, want 5", d); end
    do_read(7, 4, d);
    n_checks++;
    if (d !== 3'b101) begin n_fail++; $display("FAIL clear_read_7_4: got %0d, want 5", d); end
  endtask

  task automatic test_priority;
    int cnt; bit rdy_seen; logic [2:0] d;
    @(negedge clk); clear = 1'b1; start = 1'b1; fill_rgb = 3'b010;
    @(negedge clk); clear = 1'b0; start = 1'b0;
    cnt = 0; rdy_seen = 1'b0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      if (pix_ready !== 1'b0) rdy_seen = 1'b1;
      start = (cnt % 7 == 0);
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (cnt !== 176 || done !== 1'b1 || rdy_seen !== 1'b0) begin
      n_fail++; $display("FAIL prio_clear_path: got busy=%0d done=%b ready_seen=%0d, want 176 1 0",
                         cnt, done, rdy_seen);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      n_fail++; $display("FAIL prio_idle: got busy=%b ready=%b, want 0 0", busy, pix_ready);
    end
    do_read(3, 5, d);
    n_checks++;
    if (d !== 3'b010) begin n_fail++; $display("FAIL prio_fill: got %0d, want 2", d); end
  endtask

  task automatic test_oob_read;
    logic [2:0] d;
    int rows[3] = '{16, 0, 1023};
    int cols[3] = '{0, 11, 1023};
    for (int k = 0; k < 3; k++) begin
      do_read(2, 2, d); // in-range read leaves a non-zero value on rd_rgb
      do_read(rows[k], cols[k], d);
      n_checks++;
      if (d !== 3'd0) begin
        n_fail++; $display("FAIL oob_read_%0d_%0d: got %0d, want 0", rows[k], cols[k], d);
      end
    end
  endtask

  task automatic test_reset_abort;
    int acc, rdy, dones; bit sd; logic [2:0] d;
    @(negedge clk); start = 1'b1;
    feed(0, 50, 1'b0, 1'b0, acc, sd, rdy);
    @(negedge clk); pix_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    dones = 0;
    n_checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: got busy=%b ready=%b done=%b, want 0 0 0", busy, pix_ready, done);
    end
    repeat (4) begin @(negedge clk); if (done !== 1'b0) dones++; end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done cycles, want 0", dones); end
    @(negedge clk); start = 1'b1;
    feed(0, 50, 1'b0, 1'b1, acc, sd, rdy);
    @(negedge clk); pix_valid = 1'b0;
    do_read(0, 0, d);
    n_checks++;
    if (d !== 3'd7) begin n_fail++; $display("FAIL abort_restart_0_0: got %0d, want 7", d); end
    do_read(4, 5, d);
    n_checks++;
    if (d !== 3'd6) begin n_fail++; $display("FAIL abort_pix49: got %0d, want 6", d); end
    do_read(4, 6, d);
    n_checks++;
    if (d !== 3'b010) begin n_fail++; $display("FAIL abort_pix50_retained: got %0d, want 2", d); end
    feed(50, 126, 1'b0, 1'b1, acc, sd, rdy);
    @(negedge clk); pix_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || sd !== 1'b0) begin
      n_fail++; $display("FAIL abort_reload_done: got done=%b early=%0d, want 1 0", done, sd);
    end
    do_read(15, 10, d);
    n_checks++;
    if (d !== 3'd0) begin n_fail++; $display("FAIL abort_reload_last: got %0d, want 0", d); end
  endtask

  initial begin
    test_reset();
    test_stream_load();
    test_gapped_load();
    test_clear();
    test_priority();
    test_oob_read();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
